i2c_master_nb: RTL and testbench

Parametrised I2C master, successor to the fixed 16-bit transmitter. Runs complete START / address+R/W / N data bytes / STOP transactions with a programmable SCL divider and a per-transaction byte count. Checks slave ACKs on writes and generates master ACK/NACK on reads. Sits between the CPU-side register interface and the SDA/SCL pad logic.

---
 rtl/i2c_master_nb.sv | 268 ++++++++++++++++++++++++++
 tb/tb_i2c_master_nb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_nb.sv
// i2c_master_nb: I2C master running START / address+R/W / N data bytes / STOP with a programmable SCL divider.
// Pad outputs are registered from the next-state decode, so they change on the same edge as the FSM.
module i2c_master_nb #(
  parameter int CLK_DIV   = 2,
  parameter int MAX_BYTES = 2,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_stb,
  input  logic                   rnw,
  input  logic [6:0]             i2c_addr,
  input  logic [NB_W-1:0]        num_bytes,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  input  logic                   sda_in,
  output logic                   scl,
  output logic                   sda_out,
  output logic                   sda_oe,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   nack
);
  localparam int DW    = 8 * MAX_BYTES;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WR_BYTE  = 4'd4,
    S_WR_ACK   = 4'd5,
    S_RD_BYTE  = 4'd6,
    S_RD_ACK   = 4'd7,
    S_STOP     = 4'd8
  } state_t;

  state_t            r_state, w_state_n;
  logic [DIV_W-1:0]  r_div, w_div_n;
  logic [1:0]        r_q, w_q_n;
  logic [2:0]        r_bit, w_bit_n;
  logic [NB_W-1:0]   r_byte, w_byte_n;
  logic [NB_W-1:0]   r_nb, w_nb_n;
  logic              r_rnw, w_rnw_n;
  logic [7:0]        r_shift, w_shift_n;
  logic [DW-1:0]     r_wdata, w_wdata_n;
  logic              r_ack, w_ack_n;
  logic [DW-1:0]     r_rd, w_rd_n;
  logic              r_nack, w_nack_n;
  logic              w_done_n;
  logic              r_scl, r_sda_out, r_sda_oe, r_busy, r_done;
  logic              w_scl_n, w_sda_n, w_oe_n;
  logic              w_q_end, w_sample, w_slot_end, w_last;
  logic [NB_W-1:0]   w_nb_clamp;

  assign w_q_end    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_sample   = w_q_end && (r_q == 2'd2);
  assign w_slot_end = w_q_end && (r_q == 2'd3);
  assign w_last     = ((r_byte + NB_W'(1)) == r_nb);
  assign w_nb_clamp = (num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes;

  // Next-state logic: quarter timebase, bit/byte sequencing, SDA sampling
  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_q_n     = r_q;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte;
    w_nb_n    = r_nb;
    w_rnw_n   = r_rnw;
    w_shift_n = r_shift;
    w_wdata_n = r_wdata;
    w_ack_n   = r_ack;
    w_rd_n    = r_rd;
    w_nack_n  = r_nack;
    w_done_n  = 1'b0;
    if (r_state == S_IDLE) begin
      w_div_n = {DIV_W{1'b0}};
      w_q_n   = 2'd0;
      if (start_stb) begin
        w_state_n = S_START;
        w_bit_n   = 3'd0;
        w_byte_n  = {NB_W{1'b0}};
        w_nb_n    = w_nb_clamp;
        w_rnw_n   = rnw;
        w_shift_n = {i2c_addr, rnw};
        // Left-align the used bytes so byte 0 always sits at the top
        w_wdata_n = wr_data << (8 * (MAX_BYTES - int'(w_nb_clamp)));
        w_rd_n    = {DW{1'b0}};
        w_nack_n  = 1'b0;
      end else begin
        w_state_n = S_IDLE;
      end
    end else begin
      if (w_q_end) begin
        w_div_n = {DIV_W{1'b0}};
        w_q_n   = r_q + 2'd1;
      end else begin
        w_div_n = r_div + DIV_W'(1);
      end
      if (w_sample) begin
        w_ack_n = sda_in;
        if (r_state == S_RD_BYTE) begin
          w_rd_n = {r_rd[DW-2:0], sda_in};
        end else begin
          w_rd_n = r_rd;
        end
      end else begin
        w_ack_n = r_ack;
      end
      if (w_slot_end) begin
        case (r_state)
          S_START: begin
            w_state_n = S_ADDR;
            w_bit_n   = 3'd0;
          end
          S_ADDR, S_WR_BYTE: begin
            if (r_bit == 3'd7) begin
              w_state_n = (r_state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
            end else begin
              w_bit_n   = r_bit + 3'd1;
              w_shift_n = {r_shift[6:0], 1'b0};
            end
          end
          S_ADDR_ACK: begin
            if (r_ack) begin
              w_nack_n  = 1'b1;
              w_state_n = S_STOP;
            end else if (r_nb == {NB_W{1'b0}}) begin
              w_state_n = S_STOP;
            end else if (r_rnw) begin
              w_state_n = S_RD_BYTE;
              w_bit_n   = 3'd0;
            end else begin
              w_state_n = S_WR_BYTE;
              w_bit_n   = 3'd0;
              w_shift_n = r_wdata[DW-1 -: 8];
              w_wdata_n = r_wdata << 8;
            end
          end
          S_WR_ACK: begin
            if (r_ack) begin
              w_nack_n  = 1'b1;
              w_state_n = S_STOP;
            end else if (w_last) begin
              w_state_n = S_STOP;
            end else begin
              w_state_n = S_WR_BYTE;
              w_byte_n  = r_byte + NB_W'(1);
              w_bit_n   = 3'd0;
              w_shift_n = r_wdata[DW-1 -: 8];
              w_wdata_n = r_wdata << 8;
            end
          end
          S_RD_BYTE: begin
            if (r_bit == 3'd7) begin
              w_state_n = S_RD_ACK;
            end else begin
              w_bit_n = r_bit + 3'd1;
            end
          end
          S_RD_ACK: begin
            if (w_last) begin
              w_state_n = S_STOP;
            end else begin
              w_state_n = S_RD_BYTE;
              w_byte_n  = r_byte + NB_W'(1);
              w_bit_n   = 3'd0;
            end
          end
          S_STOP: begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end
          default: w_state_n = S_IDLE;
        endcase
      end else begin
        w_state_n = r_state;
      end
    end
  end

  // Pad decode of the upcoming state/quarter; SCL is high in q2-q3 of every data slot
  always_comb begin
    w_scl_n = 1'b1;
    w_sda_n = 1'b1;
    w_oe_n  = 1'b0;
    case (w_state_n)
      S_START: begin
        w_oe_n  = 1'b1;
        w_sda_n = ~w_q_n[1];
      end
      S_ADDR, S_WR_BYTE: begin
        w_scl_n = w_q_n[1];
        w_oe_n  = 1'b1;
        w_sda_n = w_shift_n[7];
      end
      S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: begin
        w_scl_n = w_q_n[1];
      end
      S_RD_ACK: begin
        w_scl_n = w_q_n[1];
        w_oe_n  = 1'b1;
        w_sda_n = ((w_byte_n + NB_W'(1)) == w_nb_n);
      end
      S_STOP: begin
        w_scl_n = w_q_n[1];
        w_oe_n  = 1'b1;
        w_sda_n = (w_q_n == 2'd3);
      end
      default: begin
        w_scl_n = 1'b1;
        w_sda_n = 1'b1;
        w_oe_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= {DIV_W{1'b0}};
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_byte    <= {NB_W{1'b0}};
      r_nb      <= {NB_W{1'b0}};
      r_rnw     <= 1'b0;
      r_shift   <= 8'd0;
      r_wdata   <= {DW{1'b0}};
      r_ack     <= 1'b1;
      r_rd      <= {DW{1'b0}};
      r_nack    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_out <= 1'b1;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_div     <= w_div_n;
      r_q       <= w_q_n;
      r_bit     <= w_bit_n;
      r_byte    <= w_byte_n;
      r_nb      <= w_nb_n;
      r_rnw     <= w_rnw_n;
      r_shift   <= w_shift_n;
      r_wdata   <= w_wdata_n;
      r_ack     <= w_ack_n;
      r_rd      <= w_rd_n;
      r_nack    <= w_nack_n;
      r_scl     <= w_scl_n;
      r_sda_out <= w_sda_n;
      r_sda_oe  <= w_oe_n;
      r_busy    <= (w_state_n != S_IDLE);
      r_done    <= w_done_n;
    end
  end

  assign scl     = r_scl;
  assign sda_out = r_sda_out;
  assign sda_oe  = r_sda_oe;
  assign rd_data = r_rd;
  assign busy    = r_busy;
  assign done    = r_done;
  assign nack    = r_nack;
endmodule

// File: tb/tb_i2c_master_nb.sv
// Scoreboard bench for i2c_master_nb: a behavioural slave decodes bus frames and a done monitor checks results.
module tb_i2c_master_nb;
  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 2;
  localparam int NB_W      = $clog2(MAX_BYTES + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_stb = 1'b0;
  logic            rnw = 1'b0;
  logic [6:0]      i2c_addr = 7'd0;
  logic [NB_W-1:0] num_bytes = '0;
  logic [15:0]     wr_data = 16'd0;
  logic            sda_in, scl, sda_out, sda_oe, busy, done, nack;
  logic [15:0]     rd_data;
  logic            s_drv = 1'b1;

  // open-drain SDA: the slave can only pull low
  assign sda_in = (sda_oe ? sda_out : 1'b1) & s_drv;

  always #5 clk = ~clk;

  i2c_master_nb #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .start_stb(start_stb), .rnw(rnw), .i2c_addr(i2c_addr),
    .num_bytes(num_bytes), .wr_data(wr_data), .sda_in(sda_in), .scl(scl),
    .sda_out(sda_out), .sda_oe(sda_oe), .rd_data(rd_data), .busy(busy),
    .done(done), .nack(nack)
  );

  typedef struct packed { logic [7:0] b; logic a; } frame_t;
  typedef struct packed { logic nk; logic [15:0] rd; logic [31:0] len; } txn_t;

  frame_t exp_f[$];
  txn_t   exp_t[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, done_cnt = 0, frame_cnt = 0;
  int s_nack_frame = -1, s_nrd = 0;
  logic [7:0] s_rd [4];

  // slave state
  logic s_pscl = 1'b1, s_psda = 1'b1, s_act = 1'b0, s_rdtr = 1'b0;
  int   s_bc = 0, s_bi = 0;
  logic [7:0] s_rx = 8'd0;
  frame_t s_e;
  txn_t   m_e;
  logic   m_pdone = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // behavioural slave: decodes frames on SCL rise, drives ACK / read data after SCL fall
  initial forever begin
    @(negedge clk);
    if (scl && s_pscl && s_psda && !sda_in) begin
      s_act = 1'b1; s_bc = 0; s_bi = 0; s_drv = 1'b1;
    end else if (scl && s_pscl && !s_psda && sda_in) begin
      s_act = 1'b0; s_drv = 1'b1;
    end else if (s_act && scl && !s_pscl) begin
      if (s_bc < 8) begin
        s_rx = {s_rx[6:0], sda_in};
        s_bc++;
        if (s_bc == 8 && s_bi == 0) s_rdtr = s_rx[0];
      end else begin
        frame_cnt++;
        if (exp_f.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame: unexpected byte %h ack %b", s_rx, sda_in);
        end else begin
          s_e = exp_f.pop_front();
          chk("frame", {23'd0, s_rx, sda_in}, {23'd0, s_e.b, s_e.a});
        end
        s_bc = 9;
      end
    end else if (s_act && !scl && s_pscl) begin
      if (s_bc == 8) begin
        s_drv = (s_bi == 0 || !s_rdtr) ? (s_bi == s_nack_frame) : 1'b1;
      end else if (s_bc == 9) begin
        s_bi++; s_bc = 0;
        s_drv = (s_rdtr && s_bi <= s_nrd) ? s_rd[s_bi-1][7] : 1'b1;
      end else if (s_bc > 0 && s_rdtr && s_bi > 0 && s_bi <= s_nrd) begin
        s_drv = s_rd[s_bi-1][7-s_bc];
      end
    end
    s_pscl = scl;
    s_psda = sda_in;
  end

  // done monitor: pops the expected transaction result
  initial forever begin
    @(negedge clk);
    if (m_pdone) chk("done_width", {31'd0, done}, 32'd0);
    if (done) begin
      done_cnt++;
      if (exp_t.size() == 0) begin
        checks++; errors++;
        $display("FAIL done: unexpected done at cycle %0d", cyc);
      end else begin
        m_e = exp_t.pop_front();
        chk("nack", {31'd0, nack}, {31'd0, m_e.nk});
        chk("rd_data", {16'd0, rd_data}, {16'd0, m_e.rd});
        chk("length", cyc - acc_cyc, m_e.len);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    m_pdone = done;
  end

  task automatic push_f(input logic [7:0] b, input logic a);
    frame_t f;
    f.b = b; f.a = a;
    exp_f.push_back(f);
  endtask

  task automatic push_t(input logic nk, input logic [15:0] rd, input int slots);
    txn_t t;
    t.nk = nk; t.rd = rd; t.len = slots * 4 * CLK_DIV;
    exp_t.push_back(t);
  endtask

  task automatic run(input logic r, input logic [6:0] a, input logic [NB_W-1:0] n, input logic [15:0] wd);
    @(negedge clk);
    rnw = r; i2c_addr = a; num_bytes = n; wr_data = wd; start_stb = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start_stb = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt < n) begin
      checks++; errors++;
      $display("FAIL timeout: done count %0d expected %0d", done_cnt, n);
    end
    @(negedge clk);
  endtask

  initial begin
    int f0, k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda_out", {31'd0, sda_out}, 32'd1);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy_done_nack", {29'd0, busy, done, nack}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // write 0x5A, two bytes
    push_f(8'hB4, 1'b0); push_f(8'hA5, 1'b0); push_f(8'hC3, 1'b0);
    push_t(1'b0, 16'h0000, 29);
    run(1'b0, 7'h5A, 2'd2, 16'hA5C3);
    wait_done(1);

    // read 0x21, slave returns 0x3C, 0x81; master ACK then NACK
    s_rd[0] = 8'h3C; s_rd[1] = 8'h81; s_nrd = 2;
    push_f(8'h43, 1'b0); push_f(8'h3C, 1'b0); push_f(8'h81, 1'b1);
    push_t(1'b0, 16'h3C81, 29);
    run(1'b1, 7'h21, 2'd2, 16'h0000);
    wait_done(2);
    s_nrd = 0;

    // address NACK
    s_nack_frame = 0;
    push_f(8'h20, 1'b1);
    push_t(1'b1, 16'h0000, 11);
    run(1'b0, 7'h10, 2'd2, 16'h1234);
    wait_done(3);
    s_nack_frame = -1;

    // address-only probe
    push_f(8'h7E, 1'b0);
    push_t(1'b0, 16'h0000, 11);
    run(1'b0, 7'h3F, 2'd0, 16'hFFFF);
    wait_done(4);

    // num_bytes=3 clamps to 2; start_stb and input changes while busy are ignored
    push_f(8'hAA, 1'b0); push_f(8'hDE, 1'b0); push_f(8'hAD, 1'b0);
    push_t(1'b0, 16'h0000, 29);
    run(1'b0, 7'h55, 2'd3, 16'hDEAD);
    repeat (50) @(negedge clk);
    start_stb = 1'b1; i2c_addr = 7'h01; rnw = 1'b1; wr_data = 16'h0000; num_bytes = 2'd1;
    repeat (5) @(negedge clk);
    start_stb = 1'b0;
    wait_done(5);
    repeat (100) @(negedge clk);
    chk("no_extra_txn_busy", {31'd0, busy}, 32'd0);
    chk("no_extra_txn_done", done_cnt, 32'd5);

    // NACK on first data byte
    s_nack_frame = 1;
    push_f(8'h1E, 1'b0); push_f(8'h77, 1'b1);
    push_t(1'b1, 16'h0000, 20);
    run(1'b0, 7'h0F, 2'd2, 16'h7788);
    wait_done(6);
    s_nack_frame = -1;

    // reset during WR_BYTE
    f0 = frame_cnt;
    push_f(8'h66, 1'b0);
    run(1'b0, 7'h33, 2'd2, 16'hF00F);
    k = 0;
    while (frame_cnt == f0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (frame_cnt == f0) begin
      checks++; errors++;
      $display("FAIL timeout: address frame not seen before reset");
    end
    repeat (16) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_scl", {31'd0, scl}, 32'd1);
    chk("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt, 32'd6);

    // fresh single-byte write after reset
    push_f(8'h84, 1'b0); push_f(8'h99, 1'b0);
    push_t(1'b0, 16'h0000, 20);
    run(1'b0, 7'h42, 2'd1, 16'h0199);
    wait_done(7);

    repeat (10) @(negedge clk);
    chk("frames_left", exp_f.size(), 32'd0);
    chk("txns_left", exp_t.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
